// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC host bridge: widths, transfer counts,
// down-counter width and the bridge state encoding.
package cordic_pkg;

    // Angle and result width; the core pin protocol is built around 16 bits.
    localparam int ANGLE_W    = 16;

    // An angle leaves as four nibbles and a result comes back as four bytes.
    localparam int NIB_COUNT  = 4;
    localparam int BYTE_COUNT = 4;

    // Down-counter width, wide enough for the largest legal latency (255).
    localparam int CTR_W      = 8;

    // Bridge states: idle, nibble send, core latency wait, byte receive,
    // and result hold until the host takes it.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

endpackage

// File: rtl/cordic_wait_ctr.sv
// Loadable down-counter shared by the SEND, WAIT and RECV phases.
// A load has priority over a decrement, and the count never wraps below zero.
module cordic_wait_ctr
    import cordic_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CTR_W-1:0] load_value,
    input  logic             dec,
    output logic [CTR_W-1:0] count,
    output logic             zero
);

    // Count register: cleared by reset, reloaded at each phase start, stepped down within a phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cordic_host_bridge.sv
// Host-side bridge to a nibble-in / byte-out CORDIC core.
// Accepts an angle from the host, shifts it to the core MS nibble first,
// waits the core latency, collects cos/sin as four bytes and holds the
// result until the host acknowledges it.
module cordic_host_bridge #(
    parameter int LATENCY = 16,
    parameter int ANGLE_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ANGLE_W-1:0] cmd_angle,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [ANGLE_W-1:0] res_cos,
    output logic [ANGLE_W-1:0] res_sin,
    output logic [3:0]         dut_nib,
    output logic               dut_load,
    input  logic [7:0]         dut_out,
    output logic               busy
);
    import cordic_pkg::*;

    // Counter start values: each phase counts down to zero, so it lasts start+1 cycles.
    localparam logic [CTR_W-1:0] NIB_LAST  = CTR_W'(NIB_COUNT - 1);
    localparam logic [CTR_W-1:0] BYTE_LAST = CTR_W'(BYTE_COUNT - 1);
    localparam logic [CTR_W-1:0] WAIT_LAST = CTR_W'(LATENCY - 1);

    // Counter values identifying which nibble goes out / which byte comes in.
    localparam logic [CTR_W-1:0] SLOT_3 = CTR_W'(3);
    localparam logic [CTR_W-1:0] SLOT_2 = CTR_W'(2);
    localparam logic [CTR_W-1:0] SLOT_1 = CTR_W'(1);
    localparam logic [CTR_W-1:0] SLOT_0 = CTR_W'(0);

    state_t             state;
    state_t             state_next;
    logic [ANGLE_W-1:0] angle_q;
    logic               accept;

    logic               ctr_load;
    logic [CTR_W-1:0]   ctr_load_value;
    logic               ctr_dec;
    logic [CTR_W-1:0]   ctr_count;
    logic               ctr_zero;

    // Phase counter: nibble index in SEND, remaining latency in WAIT, byte index in RECV.
    cordic_wait_ctr u_wait_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ctr_load),
        .load_value (ctr_load_value),
        .dec        (ctr_dec),
        .count      (ctr_count),
        .zero       (ctr_zero)
    );

    // The host may only hand over an angle while idle and out of reset.
    assign cmd_ready = rst_n && (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, counter control and core/host strobes decoded from the current state.
    always_comb begin
        state_next     = state;
        ctr_load       = 1'b0;
        ctr_load_value = '0;
        ctr_dec        = 1'b0;
        dut_load       = 1'b0;
        dut_nib        = 4'h0;
        res_valid      = 1'b0;
        busy           = 1'b1;

        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (cmd_valid) begin
                    state_next     = ST_SEND;
                    ctr_load       = 1'b1;
                    ctr_load_value = NIB_LAST;
                end
            end

            ST_SEND: begin
                dut_load = 1'b1;
                case (ctr_count)
                    SLOT_3:  dut_nib = angle_q[15:12];
                    SLOT_2:  dut_nib = angle_q[11:8];
                    SLOT_1:  dut_nib = angle_q[7:4];
                    SLOT_0:  dut_nib = angle_q[3:0];
                    default: dut_nib = 4'h0;
                endcase
                if (ctr_zero) begin
                    state_next     = ST_WAIT;
                    ctr_load       = 1'b1;
                    ctr_load_value = WAIT_LAST;
                end else begin
                    ctr_dec = 1'b1;
                end
            end

            ST_WAIT: begin
                if (ctr_zero) begin
                    state_next     = ST_RECV;
                    ctr_load       = 1'b1;
                    ctr_load_value = BYTE_LAST;
                end else begin
                    ctr_dec = 1'b1;
                end
            end

            ST_RECV: begin
                if (ctr_zero) begin
                    state_next = ST_HOLD;
                end else begin
                    ctr_dec = 1'b1;
                end
            end

            ST_HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Angle is captured on accept and held for the whole nibble transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            angle_q <= '0;
        end else if (accept) begin
            angle_q <= cmd_angle;
        end
    end

    // Result bytes land only during RECV, so core output noise elsewhere is ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_cos <= '0;
            res_sin <= '0;
        end else if (state == ST_RECV) begin
            case (ctr_count)
                SLOT_3:  res_cos[15:8] <= dut_out;
                SLOT_2:  res_cos[7:0]  <= dut_out;
                SLOT_1:  res_sin[15:8] <= dut_out;
                SLOT_0:  res_sin[7:0]  <= dut_out;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cordic_host_bridge.md
CORDIC_HOST_BRIDGE -- requirements
Module: cordic_host_bridge

Interface
REQ-001 SHALL have parameter LATENCY, default 16: number of idle cycles between the last angle nibble and the first result byte (legal range 1..255).
REQ-002 SHALL have parameter ANGLE_W, default 16: angle and result width (fixed at 16 for this release).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset is synchronous and active-low.
REQ-005 SHALL have port cmd_valid, input, 1: host offers an angle.
REQ-006 SHALL have port cmd_ready, output, 1: bridge accepts an angle.
REQ-007 SHALL have port cmd_angle, input, 16: angle, sampled on accept.
REQ-008 SHALL have port res_valid, output, 1: result available.
REQ-009 SHALL have port res_ready, input, 1: host takes the result.
REQ-010 SHALL have port res_cos, output, 16: captured cosine.
REQ-011 SHALL have port res_sin, output, 16: captured sine.
REQ-012 SHALL have port dut_nib, output, 4: angle nibble driven to the CORDIC core pins.
REQ-013 SHALL have port dut_load, output, 1: nibble strobe to the CORDIC core.
REQ-014 SHALL have port dut_out, input, 8: result byte stream from the CORDIC core.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, SEND, WAIT, RECV and HOLD.
REQ-017 SHALL assert cmd_ready only in IDLE, and SHALL ignore cmd_valid in every other state.
REQ-018 SHALL, on accept (cmd_valid & cmd_ready at edge T), latch cmd_angle and enter SEND.
REQ-019 SHALL, in SEND (cycles T+1..T+4), drive dut_load=1 with dut_nib = angle[15:12], [11:8], [7:4], [3:0] in order, MS nibble first.
REQ-020 SHALL drive dut_load=0 and dut_nib=0 outside SEND.
REQ-021 SHALL stay in WAIT for exactly LATENCY cycles (T+5..T+4+LATENCY), counting down.
REQ-022 SHALL, in RECV, sample dut_out on 4 consecutive edges (cycles T+5+LATENCY..T+8+LATENCY) in the order cos[15:8], cos[7:0], sin[15:8], sin[7:0].
REQ-023 SHALL assert res_valid from cycle T+9+LATENCY in HOLD, holding res_cos and res_sin stable until res_valid & res_ready.
REQ-024 SHALL, on res handshake, deassert res_valid and return to IDLE on the next cycle; cmd_ready therefore rises one cycle after the handshake.
REQ-025 SHALL keep res_cos and res_sin at the last captured values after the handshake, until the next RECV overwrites them.
REQ-026 SHALL, if res_ready is already high when res_valid rises, complete the handshake in that first HOLD cycle.
REQ-027 SHALL not let dut_out changes outside RECV affect any output.

Reset
REQ-028 SHALL, when rst_n=0 at a clock edge, enter IDLE with res_valid=0, res_cos=0, res_sin=0, dut_load=0, dut_nib=0, busy=0 and the counter at 0.
REQ-029 SHALL hold cmd_ready=0 while rst_n=0, and assert it on the first edge with rst_n=1.
REQ-030 SHALL, on reset mid-transaction in any state, abort the transaction with no partial result and no further dut_load pulses.

Structure
REQ-031 SHALL place ANGLE_W, the nibble count (4), the byte count (4) and the state enum in the shared package cordic_pkg.
REQ-032 SHALL implement the WAIT/SEND/RECV down-counter as sub-module cordic_wait_ctr (load, decrement, zero flag); everything else stays in the top module.

Verification
REQ-033 SHALL verify basic transfer: LATENCY=16, angle 0x1234 accepted at T -> dut_nib 1,2,3,4 with dut_load=1 at T+1..T+4; dut_out A5,5A,0F,F0 at T+21..T+24 -> res_cos=0xA55A, res_sin=0x0FF0, res_valid at T+25.
REQ-034 SHALL verify backpressure: res_ready=0 for 10 cycles after res_valid -> res_valid and data stay stable, cmd_ready stays 0; res_ready=1 -> IDLE next cycle.
REQ-035 SHALL verify busy rejection: cmd_valid held high with new angle 0xFFFF during SEND/WAIT -> cmd_ready=0 and the first angle's nibbles are unchanged; 0xFFFF is accepted only after return to IDLE.
REQ-036 SHALL verify reset in WAIT: rst_n=0 for one edge at T+10 -> IDLE, res_valid never asserts, dut_load stays 0, cmd_ready=1 the edge after release.
REQ-037 SHALL verify minimum latency: LATENCY=1, angle 0x8000 -> first byte sampled at T+6, res_valid at T+10.
REQ-038 SHALL verify back-to-back: two angles with res_ready tied high -> second accept one cycle after the first handshake, and both results are correct.
